// File: rtl/cic_decim_shifter.sv
// N-stage CIC decimator: integrators on the fast strobe, combs on the decimated strobe,
// output rescaled by the smallest power of two covering rate^N so passband gain stays in (0.5, 1].
module cic_decim_shifter #(
  parameter int bw               = 16,
  parameter int N                = 4,
  parameter int log2_of_max_rate = 9
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [log2_of_max_rate-1:0] rate,
  input  logic                        strobe_in,
  input  logic                        strobe_out,
  input  logic signed [bw-1:0]        signal_in,
  output logic signed [bw-1:0]        signal_out,
  output logic                        valid_out
);

  localparam int ACC = bw + N*log2_of_max_rate;
  localparam int PW  = N*log2_of_max_rate;
  localparam int SW  = $clog2(PW + 1);

  logic signed [ACC-1:0] integ [N];
  logic signed [ACC-1:0] dly   [N];
  logic signed [ACC-1:0] dif   [N];
  logic signed [ACC-1:0] scaled;
  logic signed [ACC-1:0] sample_ext;

  logic [PW-1:0] rate_ext;
  logic [PW-1:0] rate_pow;
  logic [PW-1:0] rate_pow_m1;
  logic [SW-1:0] shift_next;
  logic [SW-1:0] shift_r;
  logic          stb_d1;

  assign rate_ext   = PW'(rate);
  assign sample_ext = {{(ACC-bw){signal_in[bw-1]}}, signal_in};

  // shift = ceil(log2(rate^N)); rate^N always fits in PW bits, so no overflow here.
  always_comb begin
    rate_pow    = PW'(1);
    shift_next  = '0;
    for (int k = 0; k < N; k++) begin
      rate_pow = rate_pow * rate_ext;
    end
    rate_pow_m1 = rate_pow - PW'(1);
    if (rate_pow > PW'(1)) begin
      for (int b = 0; b < PW; b++) begin
        if (rate_pow_m1[b]) shift_next = SW'(b + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) shift_r <= '0;
    else       shift_r <= shift_next;
  end

  assign scaled = dif[N-1] >>> shift_r;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
        dif[k]   <= '0;
      end
      stb_d1    <= 1'b0;
      valid_out <= 1'b0;
      if (reset) signal_out <= '0;
    end else begin
      // Integrators wrap freely; the comb differences undo the overflow.
      if (strobe_in) begin
        integ[0] <= integ[0] + sample_ext;
        for (int k = 1; k < N; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
      end
      if (strobe_out) begin
        dly[0] <= integ[N-1];
        dif[0] <= integ[N-1] - dly[0];
        for (int k = 1; k < N; k++) begin
          dly[k] <= dif[k-1];
          dif[k] <= dif[k-1] - dly[k];
        end
      end
      stb_d1    <= strobe_out;
      valid_out <= stb_d1;
      if (stb_d1) signal_out <= scaled[bw-1:0];
    end
  end

endmodule
